motion_bbox_tracker: RTL

- Consumes the per-pixel motion mask from the motion detection stage, one pixel per valid cycle in raster order.
- Rejects speckle noise with a horizontal run-length filter.
- Accumulates a per-frame bounding box and area of confirmed motion pixels.
- At the end of each frame, publishes the box and area for the downstream overlay/VGA box-drawing logic.

---
 rtl/motion_bbox_tracker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/motion_bbox_tracker.sv
// Run-length filtered motion bounding box tracker.
// Publishes box and area of confirmed motion pixels once per frame.
module motion_bbox_tracker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 11,
  parameter int YW       = 10,
  parameter int CW       = 20,
  parameter int THRESH   = 128,
  parameter int MIN_RUN  = 4,
  parameter int MIN_AREA = 64
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iDVAL,
  input  logic          iFrameStart,
  input  logic [9:0]    iMotion,
  output logic [XW-1:0] oX_MIN,
  output logic [XW-1:0] oX_MAX,
  output logic [YW-1:0] oY_MIN,
  output logic [YW-1:0] oY_MAX,
  output logic [CW-1:0] oArea,
  output logic          oBoxValid,
  output logic          oFrameDone
);

  localparam int RW = $clog2(MIN_RUN + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [RW-1:0] RUN_FULL = RW'(MIN_RUN);
  localparam logic [RW-1:0] RUN_PRE = RW'(MIN_RUN - 1);
  localparam logic [9:0] TH = 10'(THRESH);
  localparam logic [CW-1:0] RUN_ADD = CW'(MIN_RUN);
  localparam logic [CW-1:0] MIN_A = CW'(MIN_AREA);

  logic [XW-1:0] x, cx, nx;
  logic [YW-1:0] y, cy, ny;
  logic [RW-1:0] run_len, clen, nlen;
  logic [XW-1:0] run_start, nstart, seg;
  logic [XW-1:0] acc_xmin, acc_xmax;
  logic [YW-1:0] acc_ymin, acc_ymax;
  logic [CW-1:0] acc_area;
  logic          any_hit;
  logic [XW-1:0] cxmin, cxmax, nxmin, nxmax;
  logic [YW-1:0] cymin, cymax, nymin, nymax;
  logic [CW-1:0] carea, narea, add;
  logic [CW:0]   sum;
  logic          chit, nhit, motion, last, do_add;

  // iFrameStart acts as if the frame state had just been initialised
  always_comb begin
    cx    = iFrameStart ? '0 : x;
    cy    = iFrameStart ? '0 : y;
    clen  = iFrameStart ? '0 : run_len;
    cxmin = iFrameStart ? X_LAST : acc_xmin;
    cxmax = iFrameStart ? '0 : acc_xmax;
    cymin = iFrameStart ? Y_LAST : acc_ymin;
    cymax = iFrameStart ? '0 : acc_ymax;
    carea = iFrameStart ? '0 : acc_area;
    chit  = iFrameStart ? 1'b0 : any_hit;
    motion = iDVAL && (iMotion >= TH);
    nx     = cx;
    ny     = cy;
    nlen   = clen;
    nstart = run_start;
    nxmin  = cxmin;
    nxmax  = cxmax;
    nymin  = cymin;
    nymax  = cymax;
    nhit   = chit;
    last   = 1'b0;
    do_add = 1'b0;
    add    = '0;
    seg    = (clen == '0) ? cx : run_start;
    if (iDVAL) begin
      last = (cx == X_LAST) && (cy == Y_LAST);
      nx   = (cx == X_LAST) ? '0 : cx + 1'b1;
      if (cx == X_LAST)
        ny = (cy == Y_LAST) ? '0 : cy + 1'b1;
      if (motion) begin
        if (clen == '0)
          nstart = cx;
        if (clen != RUN_FULL)
          nlen = clen + 1'b1;
        if (clen == RUN_PRE) begin
          nxmin  = (seg < cxmin) ? seg : cxmin;
          nxmax  = (cx > cxmax) ? cx : cxmax;
          nymin  = (cy < cymin) ? cy : cymin;
          nymax  = (cy > cymax) ? cy : cymax;
          nhit   = 1'b1;
          do_add = 1'b1;
          add    = RUN_ADD;
        end else if (clen == RUN_FULL) begin
          nxmax  = (cx > cxmax) ? cx : cxmax;
          do_add = 1'b1;
          add    = CW'(1);
        end
      end else begin
        nlen = '0;
      end
      if (cx == X_LAST)
        nlen = '0;
    end
    sum   = {1'b0, carea} + {1'b0, add};
    narea = carea;
    if (do_add)
      narea = sum[CW] ? '1 : sum[CW-1:0];
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      x          <= '0;
      y          <= '0;
      run_len    <= '0;
      run_start  <= '0;
      acc_xmin   <= X_LAST;
      acc_xmax   <= '0;
      acc_ymin   <= Y_LAST;
      acc_ymax   <= '0;
      acc_area   <= '0;
      any_hit    <= 1'b0;
      oX_MIN     <= '0;
      oX_MAX     <= '0;
      oY_MIN     <= '0;
      oY_MAX     <= '0;
      oArea      <= '0;
      oBoxValid  <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      x          <= nx;
      y          <= ny;
      run_len    <= nlen;
      run_start  <= nstart;
      oFrameDone <= last;
      if (last) begin
        acc_xmin <= X_LAST;
        acc_xmax <= '0;
        acc_ymin <= Y_LAST;
        acc_ymax <= '0;
        acc_area <= '0;
        any_hit  <= 1'b0;
        oArea    <= narea;
        if (nhit && (narea >= MIN_A)) begin
          oBoxValid <= 1'b1;
          oX_MIN    <= nxmin;
          oX_MAX    <= nxmax;
          oY_MIN    <= nymin;
          oY_MAX    <= nymax;
        end else begin
          oBoxValid <= 1'b0;
          oX_MIN    <= '0;
          oX_MAX    <= '0;
          oY_MIN    <= '0;
          oY_MAX    <= '0;
        end
      end else begin
        acc_xmin <= nxmin;
        acc_xmax <= nxmax;
        acc_ymin <= nymin;
        acc_ymax <= nymax;
        acc_area <= narea;
        any_hit  <= nhit;
      end
    end
  end

endmodule
